// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-button pin and the controller that
// consumes the conditioned button events. The conditioner attaches through
// the slave modport; whatever drives the pin and watches the events uses master.
interface button_conditioner_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner. Stages: a 2-flop synchronizer, then a debounce FSM
// that produces a debounced level plus one-cycle press, release and long-press
// strobes.
// Optional macro AUTO_REPEAT_EN: while the long press continues to be held,
// press_pulse repeats every REPEAT_CYCLES cycles. The REPEAT_CYCLES parameter
// is declared only when AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int DB_CYCLES   = 500000,
  parameter int LONG_CYCLES = 50000000
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 10000000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   btn
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    LONG_HELD,
    DB_RELEASE
  } state_t;

  logic [1:0]        sync_q;
  logic              btn_sync;
  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
`ifdef AUTO_REPEAT_EN
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
`endif

  assign btn_sync = sync_q[1];

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;

  // Two back-to-back flops bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn.btn_raw};
    end
  end

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef AUTO_REPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
`endif
    end
  end

  // Debounce transitions and next values of the strobes and counters.
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end

      DB_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      HELD: begin
        if (!btn_sync) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d     = LONG_HELD;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d   = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + LONG_ONE;
        end
      end

      LONG_HELD: begin
        if (!btn_sync) begin
          state_d   = DB_RELEASE;
          db_cnt_d  = '0;
`ifdef AUTO_REPEAT_EN
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_LAST) begin
          press_d   = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_ONE;
`endif
        end
      end

      DB_RELEASE: begin
        if (btn_sync) begin
          state_d = long_flag_q ? LONG_HELD : HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          long_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + DB_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    level_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == DB_RELEASE);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DB_CYCLES=4, LONG_CYCLES=16,
// REPEAT_CYCLES=8. A run-length model of the button rules predicts every
// output each cycle; directed phases pin the absolute latencies.
module tb_button_conditioner;

  localparam int DB     = 4;
  localparam int LONG   = 16;
  localparam int REPEAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  button_conditioner_if bif ();

  button_conditioner #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_CYCLES (REPEAT)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .btn (bif.slave)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    bif.btn_raw = value;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: the pin reaches the debouncer two edges late; a change is
  // accepted once DB+1 consecutive equal samples oppose the current level.
  // Hold and repeat time advance only on edges whose sample and the one before
  // are both high.
  logic r0 = 1'b0, r1 = 1'b0, prev_s = 1'b0, run_val = 1'b0;
  int   run_len = 0, hold_t = 0, rpt_t = 0;
  logic long_done = 1'b0;
  logic m_level = 1'b0, m_press = 1'b0, m_release = 1'b0, m_long = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic s;
    if (rst) begin
      r0 = 1'b0; r1 = 1'b0; prev_s = 1'b0; run_val = 1'b0; run_len = 0;
      hold_t = 0; rpt_t = 0; long_done = 1'b0;
      m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    end else begin
      s  = r1;
      r1 = r0;
      r0 = bif.btn_raw;
      m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
      if (s == run_val) run_len++;
      else begin
        run_val = s;
        run_len = 1;
      end
      if (!m_level) begin
        if (s && run_len == DB + 1) begin
          m_level = 1'b1; m_press = 1'b1; hold_t = 0; long_done = 1'b0; rpt_t = 0;
        end
      end else begin
        if (!s && run_len == DB + 1) begin
          m_level = 1'b0; m_release = 1'b1;
        end else if (s && prev_s) begin
          if (!long_done) begin
            hold_t++;
            if (hold_t == LONG) begin
              m_long = 1'b1; long_done = 1'b1; rpt_t = 0;
            end
          end else begin
`ifdef AUTO_REPEAT_EN
            rpt_t++;
            if (rpt_t == REPEAT) begin
              m_press = 1'b1; rpt_t = 0;
            end
`endif
          end
        end else if (!s) begin
          rpt_t = 0;
        end
      end
      prev_s = s;
    end
  end

  // Every cycle: outputs versus the model, plus the one-strobe-at-a-time rule.
  always @(negedge clk) begin
    checkOutput("level",   int'(bif.btn_level),     int'(m_level));
    checkOutput("press",   int'(bif.press_pulse),   int'(m_press));
    checkOutput("release", int'(bif.release_pulse), int'(m_release));
    checkOutput("long",    int'(bif.long_pulse),    int'(m_long));
    checkOutput("exclusive",
                (int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.long_pulse)) <= 1, 1);
  end

  // Event log of strobe cycles for the directed phases.
  int press_q[$], release_q[$], long_q[$];

  always @(negedge clk) begin
    if (bif.press_pulse)   press_q.push_back(cyc);
    if (bif.release_pulse) release_q.push_back(cyc);
    if (bif.long_pulse)    long_q.push_back(cyc);
  end

  task automatic clearLog();
    press_q.delete();
    release_q.delete();
    long_q.delete();
  endtask

  // Waits (bounded) for a strobe: sel 0=press, 1=release, 2=long.
  task automatic waitEvent(input string name, input int sel, input int limit, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      hit = (sel == 0) ? bif.press_pulse : (sel == 1) ? bif.release_pulse : bif.long_pulse;
      if (hit) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, p, l, tf, r;
    bif.btn_raw = 1'b0;
    rst = 1'b1;

    // Reset held for three cycles, then idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 6);
    $display("[TB] clean press and long press");

    // Clean press followed by a long hold.
    clearLog();
    bif.btn_raw = 1'b1;
    t0 = cyc;
    waitEvent("press", 0, 20, p);
    checkOutput("press_latency", p - t0, 7);
    checkOutput("press_level", int'(bif.btn_level), 1);
    applyStimulus(1'b1, 44);
    checkOutput("long_count", long_q.size(), 1);
    if (long_q.size() > 0) begin
      l = long_q[0];
      checkOutput("long_after_press", l - p, 16);
    end else begin
      l = p + 16;
    end
`ifdef AUTO_REPEAT_EN
    checkOutput("press_count", press_q.size(), 4);
    if (press_q.size() == 4) begin
      checkOutput("repeat1", press_q[1] - l, 8);
      checkOutput("repeat2", press_q[2] - l, 16);
      checkOutput("repeat3", press_q[3] - l, 24);
    end
`else
    checkOutput("press_count", press_q.size(), 1);
`endif
    bif.btn_raw = 1'b0;
    tf = cyc;
    waitEvent("release", 1, 20, r);
    checkOutput("release_latency", r - tf, 7);
    applyStimulus(1'b0, 6);

    // Glitch of three raw cycles must be ignored.
    $display("[TB] glitch rejection");
    clearLog();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 15);
    checkOutput("glitch_press", press_q.size(), 0);
    checkOutput("glitch_level", int'(bif.btn_level), 0);

    // Bouncy release: low 2, high 1, then low for good.
    $display("[TB] bouncy release");
    clearLog();
    bif.btn_raw = 1'b1;
    waitEvent("press2", 0, 20, p);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    bif.btn_raw = 1'b0;
    tf = cyc;
    waitEvent("release2", 1, 20, r);
    checkOutput("bounce_release_latency", r - tf, 7);
    applyStimulus(1'b0, 6);
    checkOutput("bounce_release_count", release_q.size(), 1);
    checkOutput("bounce_long_count", long_q.size(), 0);

    // Reset while a release is being debounced.
    $display("[TB] reset during release debounce");
    clearLog();
    bif.btn_raw = 1'b1;
    waitEvent("press3", 0, 20, p);
    applyStimulus(1'b0, 4);
    #1 rst = 1'b1;
    #1 checkOutput("async_level_drop", int'(bif.btn_level), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 10);
    checkOutput("reset_no_release", release_q.size(), 0);
    bif.btn_raw = 1'b1;
    t0 = cyc;
    waitEvent("press4", 0, 20, p);
    checkOutput("press_after_reset_latency", p - t0, 7);
    applyStimulus(1'b1, 3);
    bif.btn_raw = 1'b0;
    waitEvent("release4", 1, 20, r);
    applyStimulus(1'b0, 4);

    // Randomised segments mixing glitches, holds, long holds and resets.
    $display("[TB] random stimulus");
    for (int k = 0; k < 250; k++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 7));
      applyStimulus(logic'($urandom_range(0, 1)), len);
    end
    applyStimulus(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Cleans the raw push-button input before it reaches the memory write/read controller, which consumes one-cycle press events to step through LED memory.
- Provides a 2-flop synchronizer, a debounce FSM, press and release pulses, a long-press event and an optional auto-repeat.
- Runs in the divided clock domain (clk_g at top level) and sits directly upstream of the controller's button input.

Parameters:
- DB_CYCLES, 500000: consecutive stable synchronized cycles needed to accept a level change; legal minimum is 2.
- LONG_CYCLES, 50000000: cycles held, counted after press acceptance, before long_pulse fires.
- REPEAT_CYCLES, 10000000: auto-repeat period; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk  input  1  block clock (clk_g domain).
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw, asynchronous button pin.
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle strobe on accepted press (and on auto-repeat).
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_pulse  output  1  one-cycle strobe when the hold reaches LONG_CYCLES.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high; the clock port is clk and the reset port is rst.
- Reset: sync[1:0]=0, state=IDLE, all counters 0, long_flag=0. All outputs are 0 while rst is high and on the first cycle after release.
- Synchronizer: btn_sync = sync[1]. It is 2 flops; no logic between them.
- Counters: db_cnt is $clog2(DB_CYCLES) bits. hold_cnt is $clog2(LONG_CYCLES) bits and saturates at LONG_CYCLES-1. All outputs are registered.
- FSM states: IDLE, DB_PRESS, HELD, LONG_HELD, DB_RELEASE.
- IDLE: btn_sync=1 -> DB_PRESS, db_cnt=0.
- DB_PRESS:
  - btn_sync=0 -> IDLE; the glitch is rejected and no pulse is produced.
  - Otherwise db_cnt increments. At db_cnt==DB_CYCLES-1 with btn_sync=1 -> HELD; press_pulse=1 and btn_level=1 on that register update; hold_cnt=0.
- HELD:
  - btn_sync=0 -> DB_RELEASE, db_cnt=0.
  - Otherwise hold_cnt increments. At hold_cnt==LONG_CYCLES-1 -> LONG_HELD; long_pulse=1 for one cycle; long_flag=1.
- LONG_HELD: btn_sync=0 -> DB_RELEASE, db_cnt=0. No further long_pulse for this press.
- DB_RELEASE:
  - btn_sync=1 -> return to HELD if long_flag=0, else LONG_HELD. hold_cnt stays frozen in DB_RELEASE; no pulse is produced.
  - Otherwise db_cnt increments. At db_cnt==DB_CYCLES-1 -> IDLE; release_pulse=1; btn_level=0; long_flag=0.
- btn_level is 1 exactly in HELD, LONG_HELD and DB_RELEASE.
- Latency: with btn_raw stable high, count the first rising edge that samples it high as edge 1. press_pulse is high for exactly the cycle following edge DB_CYCLES+3. Release latency is symmetric: release_pulse follows edge DB_CYCLES+3 after the raw fall.
- Mutual exclusion: press_pulse, release_pulse and long_pulse are never high together.
- Reset mid-operation: returns immediately to the reset state. Any pulse in flight is dropped; no release_pulse is generated.
- Glitch rejection: any btn_raw pulse shorter than DB_CYCLES cycles after synchronization produces no output change.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - An rpt_cnt of $clog2(REPEAT_CYCLES) bits runs in LONG_HELD.
  - press_pulse fires once per REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after long_pulse; rpt_cnt then reloads to 0.
  - rpt_cnt clears on entry to DB_RELEASE and does not count there.
  - A bounce back into LONG_HELD restarts the full period.
- Undefined: no rpt_cnt logic exists. press_pulse fires only once per accepted press.

Test Plan (DB_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8):
- Reset then idle: hold rst 3 cycles, btn_raw=0 -> all outputs 0 throughout; assert rst mid-hold -> btn_level drops to 0 asynchronously.
- Clean press: btn_raw rises and stays high -> press_pulse high for 1 cycle after edge 7, btn_level=1 from the same cycle.
- Glitch: btn_raw high for 3 cycles, then low -> no pulse, btn_level stays 0.
- Bouncy release: from HELD, btn_raw low 2 cycles, high 1, then low -> no release on the bounce; release_pulse exactly 1 cycle, 7 edges after the final fall; long_pulse never fires (total hold <16).
- Long press: hold 40 cycles after press_pulse.
  - Without AUTO_REPEAT_EN: long_pulse exactly once, 16 cycles after press_pulse; no extra press_pulse.
  - With AUTO_REPEAT_EN: press_pulse repeats at 8, 16 and 24 cycles after long_pulse.
- Reset mid-DB_RELEASE: assert rst -> no release_pulse; after deassert, a new press yields a normal press_pulse at 7-edge latency.
